dram_rd_prefetch: RTL and testbench

//  Read-side DRAM front end for the lenet accelerator. It sits between the DRAM read port and the

---
 rtl/lenet_pkg.sv | 16 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/dram_rd_prefetch.sv | 147 ++++++++++++++
 tb/tb_dram_rd_prefetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared defaults and FSM encoding for the lenet accelerator's DRAM read front end.
package lenet_pkg;

    localparam int ADDR_W_DFLT     = 18;
    localparam int DATA_W_DFLT     = 32;
    localparam int CNT_W_DFLT      = 16;
    localparam int FIFO_DEPTH_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head always presents the oldest entry, count is the occupancy.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
    assign do_pop_s  = pop && (count_r != '0);
    assign do_push_s = push && ((count_r != (PTR_W+1)'(DEPTH)) || do_pop_s);

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/dram_rd_prefetch.sv
// DRAM read prefetcher: issues credit-limited reads from base_addr and streams the
// returned words to the consumer through a show-ahead FIFO.
module dram_rd_prefetch
    import lenet_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DFLT,
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int CNT_W      = CNT_W_DFLT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic              busy,
    output logic              done,
    output logic              protocol_err,
    output logic              dram_en_rd,
    output logic [ADDR_W-1:0] dram_addr_rd,
    input  logic              dram_valid,
    input  logic [DATA_W-1:0] dram_data_rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  issued_r;
    logic [CNT_W-1:0]  popped_r;
    logic [OCC_W-1:0]  outst_r;
    logic [OCC_W-1:0]  fifo_count_s;
    logic [OCC_W:0]    credit_sum_s;
    logic [DATA_W-1:0] head_s;
    logic              req_s;
    logic              push_s;
    logic              pop_s;
    logic              stray_s;
    logic              last_pop_s;
    logic              busy_r;
    logic              done_r;
    logic              perr_r;

    // Responses only count against outstanding requests; anything else is a stray.
    assign push_s       = dram_valid && (outst_r != '0);
    assign stray_s      = dram_valid && (outst_r == '0);
    assign pop_s        = rd_valid && rd_ready;
    assign last_pop_s   = pop_s && ((popped_r + CNT_W'(1)) == cnt_r);
    assign credit_sum_s = {1'b0, fifo_count_s} + {1'b0, outst_r};

    // Next-state and request decode.
    always_comb begin
        state_s = state_r;
        req_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (word_cnt == '0) ? DONE : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (issued_r == cnt_r) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                    req_s   = (credit_sum_s < (OCC_W+1)'(FIFO_DEPTH));
                end
            end
            DRAIN: begin
                if (last_pop_s || (popped_r == cnt_r)) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM, address/credit/pop counters and status flags.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r  <= IDLE;
            addr_r   <= '0;
            cnt_r    <= '0;
            issued_r <= '0;
            popped_r <= '0;
            outst_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            perr_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_r == DONE);
            perr_r  <= perr_r || stray_s;
            if ((state_r == IDLE) && start) begin
                addr_r   <= base_addr;
                cnt_r    <= word_cnt;
                issued_r <= '0;
                popped_r <= '0;
            end else begin
                if (req_s) begin
                    addr_r   <= addr_r + ADDR_W'(1);
                    issued_r <= issued_r + CNT_W'(1);
                end
                if (pop_s) begin
                    popped_r <= popped_r + CNT_W'(1);
                end
            end
            case ({req_s, push_s})
                2'b10:   outst_r <= outst_r + OCC_W'(1);
                2'b01:   outst_r <= outst_r - OCC_W'(1);
                default: outst_r <= outst_r;
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .srst      (srst),
        .push      (push_s),
        .push_data (dram_data_rd),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    assign rd_valid     = (fifo_count_s != '0);
    assign rd_data      = rd_valid ? head_s : '0;
    assign dram_en_rd   = req_s;
    assign dram_addr_rd = addr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign protocol_err = perr_r;

endmodule

// File: tb/tb_dram_rd_prefetch.sv
// Scoreboard bench for dram_rd_prefetch: a DRAM model with in-order variable latency,
// an expected-word queue filled at start, and a monitor that checks every pop.
module tb_dram_rd_prefetch;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              srst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic              busy;
    logic              done;
    logic              protocol_err;
    logic              dram_en_rd;
    logic [ADDR_W-1:0] dram_addr_rd;
    logic              dram_valid;
    logic [DATA_W-1:0] dram_data_rd;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    dram_rd_prefetch dut (
        .clk(clk), .srst(srst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
        .busy(busy), .done(done), .protocol_err(protocol_err),
        .dram_en_rd(dram_en_rd), .dram_addr_rd(dram_addr_rd),
        .dram_valid(dram_valid), .dram_data_rd(dram_data_rd),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    logic [ADDR_W-1:0] pend_a[$];
    int                due_q[$];
    int lat_min = 1, lat_max = 1, ready_mode = 0;
    int req_cnt = 0, pop_cnt = 0, busy_cnt = 0, done_cnt = 0;
    int last_due = 0, last_pop_cyc = 0, done_cyc = 0, start_cyc = 0;
    int first_req_cyc = 0, last_req_cyc = 0;

    function automatic logic [DATA_W-1:0] mem_word(logic [ADDR_W-1:0] a);
        return {~a[13:0], a};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DRAM model: records requests, checks addresses and credits, returns data in order.
    initial begin
        int lat, due;
        dram_valid = 1'b0;
        dram_data_rd = '0;
        forever begin
            @(negedge clk);
            if (dram_en_rd) begin
                req_cnt++;
                if (req_cnt == 1) first_req_cyc = cyc;
                last_req_cyc = cyc;
                if (addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_req: got addr %0h expected no request", dram_addr_rd);
                end else begin
                    check("req_addr", dram_addr_rd, addr_q.pop_front());
                end
                check("credit_le_depth", (req_cnt - pop_cnt <= 8), 1);
                lat = $urandom_range(lat_max, lat_min);
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = due;
                due_q.push_back(due);
                pend_a.push_back(dram_addr_rd);
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                dram_valid = 1'b1;
                dram_data_rd = mem_word(pend_a.pop_front());
                void'(due_q.pop_front());
            end else begin
                dram_valid = 1'b0;
                dram_data_rd = '0;
            end
        end
    end

    // Consumer ready generator.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       rd_ready = 1'b0;
                1:       rd_ready = 1'b1;
                default: rd_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Monitor: pops are compared against the scoreboard; held heads must stay stable.
    initial begin
        logic              prev_hold;
        logic [DATA_W-1:0] prev_data;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (prev_hold && rd_valid) check("hold_stable", rd_data, prev_data);
            prev_hold = rd_valid && !rd_ready;
            prev_data = rd_data;
            if (rd_valid && rd_ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_word: got %0h expected none", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_xfer(logic [ADDR_W-1:0] b, logic [CNT_W-1:0] n);
        for (int i = 0; i < int'(n); i++) begin
            addr_q.push_back(b + ADDR_W'(i));
            exp_q.push_back(mem_word(b + ADDR_W'(i)));
        end
        @(negedge clk); #1;
        req_cnt = 0; pop_cnt = 0; busy_cnt = 0; done_cnt = 0;
        start = 1'b1; base_addr = b; word_cnt = n; start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk); #3;
            n++;
        end
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", budget);
        end
    endtask

    task automatic end_checks(string tag, int n);
        check({tag, "_pops"}, pop_cnt, n);
        check({tag, "_reqs"}, req_cnt, n);
        check({tag, "_exp_empty"}, exp_q.size(), 0);
        check({tag, "_busy_len"}, busy_cnt, done_cyc - start_cyc - 1);
    endtask

    initial begin
        int n;
        srst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
        cycles(3); #1;
        srst = 1'b0;
        #1;
        check("rst_outputs", {busy, done, protocol_err, dram_en_rd, rd_valid}, 5'b0);
        check("rst_addr", dram_addr_rd, 0);
        check("rst_data", rd_data, 0);

        // 1: latency 3, always ready
        lat_min = 3; lat_max = 3; ready_mode = 1;
        begin_xfer(18'h00010, 16'd4);
        wait_done(100);
        end_checks("t1", 4);
        check("t1_first_req", first_req_cyc - start_cyc, 1);
        check("t1_req_span", last_req_cyc - first_req_cyc, 3);
        check("t1_done_after_pop", done_cyc - last_pop_cyc, 2);
        cycles(2);

        // 2: consumer stalled, credits cap requests at the FIFO depth
        lat_min = 1; lat_max = 1; ready_mode = 0;
        begin_xfer(18'h00200, 16'd20);
        cycles(30); #3;
        check("t2_reqs_capped", req_cnt, 8);
        check("t2_en_low", dram_en_rd, 0);
        check("t2_full_valid", rd_valid, 1);
        ready_mode = 1;
        wait_done(300);
        end_checks("t2", 20);
        cycles(2);

        // 3: address wrap
        lat_min = 2; lat_max = 2;
        begin_xfer(18'h3FFFE, 16'd4);
        wait_done(100);
        end_checks("t3", 4);
        cycles(2);

        // 4: zero-length transfer
        begin_xfer(18'h01234, 16'd0);
        wait_done(20);
        check("t4_reqs", req_cnt, 0);
        check("t4_busy_len", busy_cnt, 1);
        check("t4_done_lat", done_cyc - start_cyc, 2);
        cycles(3); #3;
        check("t4_done_pulse", done_cnt, 1);

        // 5: reset with three reads in flight, then stray responses
        lat_min = 10; lat_max = 10;
        begin_xfer(18'h00100, 16'd20);
        n = 0;
        while (req_cnt < 3 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("t5_inflight", req_cnt, 3);
        srst = 1'b1;
        @(negedge clk); #1;
        srst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        check("t5_rst_outputs", {busy, done, protocol_err, dram_en_rd, rd_valid}, 5'b0);
        cycles(20); #3;
        check("t5_perr", protocol_err, 1);
        check("t5_fifo_empty", rd_valid, 0);
        check("t5_no_new_reqs", req_cnt, 3);
        lat_min = 1; lat_max = 1;
        begin_xfer(18'h00400, 16'd2);
        wait_done(50);
        end_checks("t5b", 2);
        check("t5_perr_sticky", protocol_err, 1);
        cycles(2);

        // 6: random latency and readiness, with starts thrown at a busy engine
        lat_min = 1; lat_max = 6; ready_mode = 2;
        begin_xfer(ADDR_W'($urandom), 16'd100);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk); #1;
            if (busy && $urandom_range(7, 0) == 0) begin
                start = 1'b1;
                base_addr = ADDR_W'($urandom);
                word_cnt = CNT_W'($urandom_range(50, 1));
            end else begin
                start = 1'b0;
            end
            n++;
        end
        start = 1'b0;
        if (done_cnt == 0) begin
            checks++; errors++;
            $display("FAIL t6_timeout: got no done expected done within 3000 cycles");
        end
        end_checks("t6", 100);
        cycles(5); #3;
        check("t6_idle", busy, 0);
        check("t6_no_stray_reqs", req_cnt, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
